// File: rtl/flash_adc_conv_ctrl_pkg.sv
// Shared definitions for the flash ADC conversion sequencer.
// The package holds the FSM state encoding, the comparator and code widths,
// the legal ranges of the timing parameters, and a majority-vote helper.
package flash_adc_conv_ctrl_pkg;

  localparam int THERM_W = 31;
  localparam int CODE_W  = 5;

  localparam int SAMPLE_CYC_MIN = 1;
  localparam int SAMPLE_CYC_MAX = 15;
  localparam int SETTLE_CYC_MIN = 0;
  localparam int SETTLE_CYC_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LATCH  = 3'd3,
    ST_ENCODE = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/flash_adc_conv_ctrl_enc.sv
// therm31_bubble_enc: combinational 31-bit thermometer to 5-bit encoder with
// 3-input majority bubble correction.
// Ports:
//   therm_i      31-bit raw comparator word, bit i = level i+1 exceeded
//   code_o       highest corrected level (0..31)
//   ovr_o        every comparator tripped (code_o == 31)
//   bubble_err_o raw word is not a clean thermometer (not 2^k-1)
module therm31_bubble_enc
  import flash_adc_conv_ctrl_pkg::*;
(
  input  logic [THERM_W-1:0] therm_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               ovr_o,
  output logic               bubble_err_o
);

  // Bit 0 is a forced 1 below level 1 and the top bit a forced 0 above
  // level 31, so t_ext[i+1] is raw bit i.
  logic [THERM_W+1:0] t_ext;
  logic [THERM_W-1:0] corr;
  logic [THERM_W:0]   raw_w;
  logic [THERM_W:0]   raw_inc;

  assign t_ext   = {1'b0, therm_i, 1'b1};
  assign raw_w   = {1'b0, therm_i};
  assign raw_inc = raw_w + {{THERM_W{1'b0}}, 1'b1};

  always_comb begin
    corr = '0;
    for (int i = 0; i < THERM_W; i++) begin
      corr[i] = maj3(t_ext[i], t_ext[i+1], t_ext[i+2]);
    end
  end

  always_comb begin
    code_o = '0;
    for (int i = 0; i < THERM_W; i++) begin
      if (corr[i]) code_o = CODE_W'(i + 1);
    end
  end

  // A value of the form 2^k-1 shares no set bit with its successor.
  assign bubble_err_o = |(raw_w & raw_inc);
  assign ovr_o        = (code_o == CODE_W'(THERM_W));

endmodule

// File: rtl/flash_adc_conv_ctrl.sv
// flash_adc_conv_ctrl: clocked conversion sequencer for the 5-bit flash ADC.
// Drives track/hold and comparator latch strobes, captures the thermometer
// word, encodes it and offers the code on a valid/ready handshake.
// Ports:
//   clk, rst_low         clock and asynchronous active-low reset
//   start, cont          single-shot request / continuous-mode enable
//   therm                31-bit comparator outputs
//   smp, cmp_lat, busy   track/hold, latch strobe, not-idle status
//   out_valid, out_ready result handshake
//   code, ovr, bubble_err result and flags, qualified by out_valid
module flash_adc_conv_ctrl
  import flash_adc_conv_ctrl_pkg::*;
#(
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_low,
  input  logic               start,
  input  logic               cont,
  input  logic [THERM_W-1:0] therm,
  output logic               smp,
  output logic               cmp_lat,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CODE_W-1:0]  code,
  output logic               ovr,
  output logic               bubble_err
);

  if (SAMPLE_CYC < SAMPLE_CYC_MIN || SAMPLE_CYC > SAMPLE_CYC_MAX ||
      SETTLE_CYC < SETTLE_CYC_MIN || SETTLE_CYC > SETTLE_CYC_MAX ||
      SAMPLE_CYC >= (1 << CNT_W) || SETTLE_CYC >= (1 << CNT_W)) begin : g_bad_param
    $error("flash_adc_conv_ctrl: illegal SAMPLE_CYC/SETTLE_CYC/CNT_W");
  end

  // Counters count down to zero, so a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [THERM_W-1:0] cap_q;
  logic               smp_q, cmp_lat_q, busy_q, out_valid_q;
  logic [CODE_W-1:0]  code_q;
  logic               ovr_q, bubble_err_q;

  logic [CODE_W-1:0]  enc_code;
  logic               enc_ovr, enc_bub;

  therm31_bubble_enc u_enc (
    .therm_i      (cap_q),
    .code_o       (enc_code),
    .ovr_o        (enc_ovr),
    .bubble_err_o (enc_bub)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          cnt_d   = SAMPLE_LD;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == '0) begin
          if (SETTLE_CYC == 0) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_LATCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_LATCH:  state_d = ST_ENCODE;
      ST_ENCODE: state_d = ST_HOLD;
      ST_HOLD: begin
        // Start requests seen while holding are deliberately dropped.
        if (out_ready) begin
          if (cont) begin
            state_d = ST_SAMPLE;
            cnt_d   = SAMPLE_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are true register outputs
  // aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cap_q        <= '0;
      smp_q        <= 1'b0;
      cmp_lat_q    <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      code_q       <= '0;
      ovr_q        <= 1'b0;
      bubble_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      smp_q       <= (state_d == ST_SAMPLE);
      cmp_lat_q   <= (state_d == ST_LATCH);
      busy_q      <= (state_d != ST_IDLE);
      out_valid_q <= (state_d == ST_HOLD);
      if (state_q == ST_LATCH) cap_q <= therm;
      if (state_q == ST_ENCODE) begin
        code_q       <= enc_code;
        ovr_q        <= enc_ovr;
        bubble_err_q <= enc_bub;
      end
    end
  end

  assign smp        = smp_q;
  assign cmp_lat    = cmp_lat_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign code       = code_q;
  assign ovr        = ovr_q;
  assign bubble_err = bubble_err_q;

endmodule

// File: tb/tb_flash_adc_conv_ctrl.sv
module tb_flash_adc_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst_low = 1'b0;
  logic        start = 1'b0, cont = 1'b0, out_ready = 1'b1;
  logic [30:0] therm = '0;
  logic        smp, cmp_lat, busy, out_valid, ovr, bubble_err;
  logic [4:0]  code;

  logic        start2 = 1'b0, cont2 = 1'b0, out_ready2 = 1'b1;
  logic [30:0] therm2 = '0;
  logic        smp2, cmp_lat2, busy2, out_valid2, ovr2, bubble_err2;
  logic [4:0]  code2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flash_adc_conv_ctrl u_dut (
    .clk(clk), .rst_low(rst_low), .start(start), .cont(cont), .therm(therm),
    .smp(smp), .cmp_lat(cmp_lat), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .code(code), .ovr(ovr), .bubble_err(bubble_err)
  );

  flash_adc_conv_ctrl #(.SAMPLE_CYC(1), .SETTLE_CYC(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_low(rst_low), .start(start2), .cont(cont2), .therm(therm2),
    .smp(smp2), .cmp_lat(cmp_lat2), .busy(busy2), .out_valid(out_valid2),
    .out_ready(out_ready2), .code(code2), .ovr(ovr2), .bubble_err(bubble_err2)
  );

  typedef struct {
    logic [30:0] t;
    logic [4:0]  code;
    logic        ovr;
    logic        bub;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses start on the main DUT and follows it until out_valid rises.
  task automatic conv1(input logic [30:0] t, output int lat, output int smp_n,
                       output int cmp_at, output int cmp_n);
    therm = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    smp_n = smp ? 1 : 0;
    cmp_n = 0;
    lat = -1;
    cmp_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (smp) smp_n++;
      if (cmp_lat) begin
        cmp_n++;
        if (cmp_at < 0) cmp_at = k;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, smp_n, cmp_at, cmp_n, n_v, prev_ov, idle_seen;
    int vt[3];

    vecs[0] = '{31'h0000007F,  5'd7,  1'b0, 1'b0};
    vecs[1] = '{31'h000000BF,  5'd7,  1'b0, 1'b1};
    vecs[2] = '{31'h7FFFFFFF,  5'd31, 1'b1, 1'b0};
    vecs[3] = '{31'h00000000,  5'd0,  1'b0, 1'b0};
    vecs[4] = '{31'h00000001,  5'd1,  1'b0, 1'b0};
    vecs[5] = '{31'h00000002,  5'd1,  1'b0, 1'b1};
    vecs[6] = '{31'h7FFFFFFE,  5'd31, 1'b1, 1'b1};
    vecs[7] = '{31'h3FFFFFFF,  5'd30, 1'b0, 1'b0};
    vecs[8] = '{31'h0000FFFF,  5'd16, 1'b0, 1'b0};
    vecs[9] = '{31'h00010000,  5'd0,  1'b0, 1'b1};

    // Reset state
    #2;
    chk("rst_outputs", int'({smp, cmp_lat, busy, out_valid, ovr, bubble_err}), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_dut2_busy", int'(busy2), 0);
    tick();
    tick();
    rst_low = 1'b1;
    tick();

    // Table of single conversions, out_ready high
    for (int i = 0; i < 10; i++) begin
      conv1(vecs[i].t, lat, smp_n, cmp_at, cmp_n);
      chk($sformatf("v%0d_latency", i), lat, 7);
      chk($sformatf("v%0d_code", i), int'(code), int'(vecs[i].code));
      chk($sformatf("v%0d_ovr", i), int'(ovr), int'(vecs[i].ovr));
      chk($sformatf("v%0d_bubble", i), int'(bubble_err), int'(vecs[i].bub));
      if (i == 0) begin
        chk("smp_cycles", smp_n, 2);
        chk("cmp_lat_cycle", cmp_at, 5);
        chk("cmp_lat_width", cmp_n, 1);
      end
      tick();
      chk($sformatf("v%0d_valid_drop", i), int'(out_valid), 0);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
    end

    // Back-pressure: HOLD for 5 cycles with therm toggling
    out_ready = 1'b0;
    conv1(31'h0000007F, lat, smp_n, cmp_at, cmp_n);
    chk("bp_latency", lat, 7);
    for (int k = 0; k < 5; k++) begin
      therm = (k % 2 == 0) ? 31'h7FFFFFFF : 31'h00000003;
      tick();
      chk("bp_code", int'(code), 7);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_strobes", int'({smp, cmp_lat}), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_accept_drop", int'(out_valid), 0);
    chk("bp_idle", int'(busy), 0);

    // Continuous mode with ignored start pulses
    cont = 1'b1;
    therm = 31'h0000001F;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_v = 0;
    prev_ov = 0;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 3 || k == 10 || k == 19) ? 1'b1 : 1'b0;
      tick();
      if (out_valid && prev_ov == 0 && n_v < 3) begin
        vt[n_v] = k;
        n_v++;
      end
      prev_ov = int'(out_valid);
    end
    start = 1'b0;
    chk("cont_count", n_v, 3);
    if (n_v == 3) begin
      chk("cont_first", vt[0], 7);
      chk("cont_gap1", vt[1] - vt[0], 8);
      chk("cont_gap2", vt[2] - vt[1], 8);
    end
    cont = 1'b0;
    idle_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!busy) begin
        idle_seen = 1;
        break;
      end
    end
    chk("cont_stop_idle", idle_seen, 1);
    chk("cont_code", int'(code), 5);

    // Asynchronous reset mid-SETTLE
    therm = 31'h0000007F;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("settle_busy_pre", int'(busy), 1);
    #2 rst_low = 1'b0;
    #1;
    chk("settle_rst_outs", int'({smp, cmp_lat, busy, out_valid, ovr, bubble_err}), 0);
    chk("settle_rst_code", int'(code), 0);
    tick();
    rst_low = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("settle_rst_idle", int'({busy, smp, out_valid}), 0);

    // Asynchronous reset mid-HOLD discards the pending code
    out_ready = 1'b0;
    conv1(31'h7FFFFFFE, lat, smp_n, cmp_at, cmp_n);
    chk("hold_pre_code", int'(code), 31);
    tick();
    #2 rst_low = 1'b0;
    #1;
    chk("hold_rst_outs", int'({smp, cmp_lat, busy, out_valid, ovr, bubble_err}), 0);
    chk("hold_rst_code", int'(code), 0);
    tick();
    rst_low = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("hold_rst_idle", int'({busy, out_valid}), 0);

    // Short configuration: SETTLE skipped
    therm2 = 31'h0000007F;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid2) begin
        lat = k;
        break;
      end
    end
    chk("short_latency", lat, 3);
    chk("short_code", int'(code2), 7);
    tick();
    chk("short_idle", int'({busy2, out_valid2}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
